store_checker: RTL and testbench

STORE_CHECKER -- requirements
Module: store_checker

---
 rtl/store_checker_pkg.sv | 15 +
 rtl/store_checker_table.sv | 32 +++
 rtl/store_checker.sv | 138 +++++++++++++
 tb/tb_store_checker.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_checker_pkg.sv
// Shared types and constants for the store checker.
package store_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PASS = 2'b10,
    S_FAIL = 2'b11
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

endpackage

// File: rtl/store_checker_table.sv
// Expected-store register file: synchronous write, combinational read.
module store_table #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] rd_addr_c,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  // Table contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_addr[widx] <= waddr;
      mem_data[widx] <= wdata;
    end
  end

  assign rd_addr_c = mem_addr[ridx];
  assign rd_data_c = mem_data[ridx];

endmodule

// File: rtl/store_checker.sv
// Checks the store stream of a processor against an expected in-order table.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000,
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = IDX_W + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [CNT_W-1:0]  cfg_num,
  input  logic              ign_en,
  input  logic [ADDR_W-1:0] ign_addr,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [15:0]       ign_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nx;
  logic [TW-1:0]     cyc;
  logic [CNT_W-1:0]  num_q;
  logic              ign_en_q;
  logic [ADDR_W-1:0] ign_addr_q;
  logic [ADDR_W-1:0] tbl_addr_c;
  logic [DATA_W-1:0] tbl_data_c;
  logic              hit_match, hit_ign, hit_mis, last_match, tmo;

  store_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk       (CLK),
    .we        (cfg_we & ~busy),
    .widx      (cfg_idx),
    .waddr     (cfg_addr),
    .wdata     (cfg_data),
    .ridx      (match_cnt[IDX_W-1:0]),
    .rd_addr_c (tbl_addr_c),
    .rd_data_c (tbl_data_c)
  );

  // Store classification (match > ignore > mismatch) and next-state logic.
  always_comb begin
    state_nx   = state;
    hit_match  = 1'b0;
    hit_ign    = 1'b0;
    hit_mis    = 1'b0;
    last_match = 1'b0;
    tmo        = (cyc == TW'(TIMEOUT - 1));
    if (MemWrite) begin
      hit_match = (DataAdr == tbl_addr_c) && (WriteData == tbl_data_c);
      hit_ign   = !hit_match && ign_en_q && (DataAdr == ign_addr_q);
      hit_mis   = !hit_match && !hit_ign;
    end
    last_match = hit_match && (CNT_W'(match_cnt + CNT_W'(1)) == num_q);
    case (state)
      S_IDLE: if (!clear && start) state_nx = (cfg_num == '0) ? S_PASS : S_RUN;
      S_RUN: begin
        if (clear)           state_nx = S_IDLE;
        else if (last_match) state_nx = S_PASS;
        else if (hit_mis)    state_nx = S_FAIL;
        else if (tmo)        state_nx = S_FAIL;
      end
      S_PASS, S_FAIL: if (clear) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, status decodes, counters and failure capture.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= FC_NONE;
      fail_addr  <= '0;
      fail_data  <= '0;
      match_cnt  <= '0;
      ign_cnt    <= '0;
      cyc        <= '0;
      num_q      <= '0;
      ign_en_q   <= 1'b0;
      ign_addr_q <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_RUN);
      pass  <= (state_nx == S_PASS);
      fail  <= (state_nx == S_FAIL);
      if (clear || (state == S_IDLE && start)) begin
        fail_code <= FC_NONE;
        fail_addr <= '0;
        fail_data <= '0;
        match_cnt <= '0;
        ign_cnt   <= '0;
        cyc       <= '0;
        if (!clear) begin
          num_q      <= cfg_num;
          ign_en_q   <= ign_en;
          ign_addr_q <= ign_addr;
        end
      end else if (state == S_RUN) begin
        cyc <= TW'(cyc + TW'(1));
        if (hit_match) match_cnt <= CNT_W'(match_cnt + CNT_W'(1));
        if (hit_ign && ign_cnt != 16'hFFFF) ign_cnt <= 16'(ign_cnt + 16'd1);
        if (hit_mis) begin
          fail_code <= FC_MISMATCH;
          fail_addr <= DataAdr;
          fail_data <= WriteData;
        end else if (state_nx == S_FAIL) begin
          fail_code <= FC_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench: directed vector table, corner sequences, random runs vs model.
module tb_store_checker;

  localparam int TMO = 20;
  localparam int RUN_CYC = 22;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0, cfg_data = '0;
  logic [2:0]  cfg_num = '0;
  logic        ign_en = 1'b0;
  logic [31:0] ign_addr = '0;
  logic        start = 1'b0, clear = 1'b0;
  logic        busy, pass, fail;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  match_cnt;
  logic [15:0] ign_cnt;

  int n_total = 0;
  int n_pass  = 0;

  store_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .ign_en(ign_en), .ign_addr(ign_addr), .start(start), .clear(clear),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .fail_addr(fail_addr),
    .fail_data(fail_data), .match_cnt(match_cnt), .ign_cnt(ign_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]       num;
    logic             ign_en;
    logic [31:0]      ign_addr;
    logic [3:0][31:0] ta;
    logic [3:0][31:0] td;
    logic [3:0]       n;
    logic [7:0]       we;
    logic [7:0][31:0] sa;
    logic [7:0][31:0] sd;
  } scn_t;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic [1:0]  fc;
    logic [31:0] fa;
    logic [31:0] fd;
    logic [2:0]  mc;
    logic [15:0] ic;
  } res_t;

  typedef struct packed {
    scn_t s;
    res_t e;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".pass"}, 64'(pass), 64'(e.pass));
    chk({tag, ".fail"}, 64'(fail), 64'(e.fail));
    chk({tag, ".fail_code"}, 64'(fail_code), 64'(e.fc));
    chk({tag, ".fail_addr"}, 64'(fail_addr), 64'(e.fa));
    chk({tag, ".fail_data"}, 64'(fail_data), 64'(e.fd));
    chk({tag, ".match_cnt"}, 64'(match_cnt), 64'(e.mc));
    chk({tag, ".ign_cnt"}, 64'(ign_cnt), 64'(e.ic));
  endtask

  task automatic chk_zero(input string tag);
    res_t z;
    z = '0;
    chk_res(tag, z);
  endtask

  // Walk the store list against the expected order; first decisive event wins.
  function automatic res_t model(input scn_t s);
    res_t r;
    int   k;
    bit   done;
    r = '0; k = 0; done = 0;
    if (s.num == 3'd0) begin
      r.pass = 1'b1;
      return r;
    end
    for (int t = 0; t < RUN_CYC && !done; t++) begin
      if (t < int'(s.n) && s.we[t]) begin
        if (k < 4 && s.sa[t] == s.ta[k] && s.sd[t] == s.td[k]) begin
          k++;
          r.mc = 3'(k);
          if (k == int'(s.num)) begin r.pass = 1'b1; done = 1; end
        end else if (s.ign_en && s.sa[t] == s.ign_addr) begin
          r.ic = 16'(r.ic + 16'd1);
        end else begin
          r.fail = 1'b1; r.fc = 2'b01; r.fa = s.sa[t]; r.fd = s.sd[t]; done = 1;
        end
      end
      if (!done && t == TMO - 1) begin r.fail = 1'b1; r.fc = 2'b10; done = 1; end
    end
    return r;
  endfunction

  task automatic pulse_clear();
    clear = 1'b1; @(negedge CLK); clear = 1'b0;
  endtask

  task automatic load_table(input scn_t s);
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_idx = 2'(i); cfg_addr = s.ta[i]; cfg_data = s.td[i];
      @(negedge CLK);
    end
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input scn_t s);
    cfg_num = s.num; ign_en = s.ign_en; ign_addr = s.ign_addr;
    start = 1'b1; @(negedge CLK); start = 1'b0;
  endtask

  // Store t is presented in RUN cycle t; runs long enough to cover the timeout.
  task automatic run_scn(input scn_t s, input bit do_cfg);
    pulse_clear();
    if (do_cfg) load_table(s);
    do_start(s);
    for (int t = 0; t < RUN_CYC; t++) begin
      if (t < int'(s.n)) begin
        MemWrite = s.we[t]; DataAdr = s.sa[t]; WriteData = s.sd[t];
      end else begin
        MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      end
      @(negedge CLK);
    end
    MemWrite = 1'b0;
  endtask

  function automatic scn_t rand_scn();
    scn_t s;
    int   j;
    s = '0;
    s.num = 3'($urandom_range(1, 4));
    s.ign_en = 1'($urandom);
    s.ign_addr = 32'(100 + 4 * $urandom_range(0, 5));
    for (int i = 0; i < 4; i++) begin
      s.ta[i] = 32'(100 + 4 * $urandom_range(0, 5));
      s.td[i] = 32'($urandom_range(0, 2));
    end
    s.n = 4'd8;
    j = 0;
    for (int t = 0; t < 8; t++) begin
      int p;
      p = $urandom_range(0, 99);
      s.we[t] = (p >= 10);
      if (p < 60 && j < 4) begin
        s.sa[t] = s.ta[j]; s.sd[t] = s.td[j];
        if (s.we[t]) j++;
      end else if (p < 85) begin
        s.sa[t] = s.ign_addr; s.sd[t] = 32'($urandom);
      end else begin
        s.sa[t] = 32'(100 + 4 * $urandom_range(0, 5)); s.sd[t] = 32'($urandom_range(0, 2));
      end
    end
    return s;
  endfunction

  function automatic vec_t base_vec();
    vec_t v;
    v = '0;
    v.s.num = 3'd1; v.s.ign_en = 1'b1; v.s.ign_addr = 32'd80;
    v.s.ta[0] = 32'd84; v.s.td[0] = 32'd71;
    v.s.ta[1] = 32'd80; v.s.td[1] = 32'd71;
    return v;
  endfunction

  initial begin
    vec_t v;
    scn_t s;
    res_t e;

    // Directed vectors with hand-derived expectations.
    v = base_vec(); v.s.n = 4'd2; v.s.we = 8'b11;
    v.s.sa[0] = 32'd80; v.s.sd[0] = 32'd5; v.s.sa[1] = 32'd84; v.s.sd[1] = 32'd71;
    v.e.pass = 1'b1; v.e.mc = 3'd1; v.e.ic = 16'd1; vecs[0] = v;

    v = base_vec(); v.s.n = 4'd1; v.s.we = 8'b1; v.s.sa[0] = 32'd88; v.s.sd[0] = 32'd71;
    v.e.fail = 1'b1; v.e.fc = 2'b01; v.e.fa = 32'd88; v.e.fd = 32'd71; vecs[1] = v;

    v = '0; v.s.num = 3'd2; v.s.ta[0] = 32'd100; v.s.td[0] = 32'd1; v.s.ta[1] = 32'd104; v.s.td[1] = 32'd2;
    v.s.n = 4'd1; v.s.we = 8'b1; v.s.sa[0] = 32'd104; v.s.sd[0] = 32'd2;
    v.e.fail = 1'b1; v.e.fc = 2'b01; v.e.fa = 32'd104; v.e.fd = 32'd2; vecs[2] = v;

    v.s.n = 4'd2; v.s.we = 8'b11; v.s.sa[0] = 32'd100; v.s.sd[0] = 32'd1; v.s.sa[1] = 32'd104; v.s.sd[1] = 32'd2;
    v.e = '0; v.e.pass = 1'b1; v.e.mc = 3'd2; vecs[3] = v;

    v = base_vec(); v.s.ign_en = 1'b0; v.s.n = 4'd1; v.s.we = 8'b1; v.s.sa[0] = 32'd80; v.s.sd[0] = 32'd5;
    v.e.fail = 1'b1; v.e.fc = 2'b01; v.e.fa = 32'd80; v.e.fd = 32'd5; vecs[4] = v;

    v = base_vec(); v.s.n = 4'd3; v.s.we = 8'b100;
    for (int i = 0; i < 3; i++) begin v.s.sa[i] = 32'd84; v.s.sd[i] = 32'd71; end
    v.e.pass = 1'b1; v.e.mc = 3'd1; vecs[5] = v;

    v = base_vec(); v.s.ta[0] = 32'h8000_0084; v.s.n = 4'd1; v.s.we = 8'b1; v.s.sa[0] = 32'd84; v.s.sd[0] = 32'd71;
    v.e.fail = 1'b1; v.e.fc = 2'b01; v.e.fa = 32'd84; v.e.fd = 32'd71; vecs[6] = v;

    v = '0; v.s.num = 3'd4; v.s.ign_en = 1'b1; v.s.ign_addr = 32'd200;
    for (int i = 0; i < 4; i++) begin v.s.ta[i] = 32'(4 * i); v.s.td[i] = 32'(10 + i); end
    v.s.n = 4'd6; v.s.we = 8'b111111;
    v.s.sa[0] = 32'd0; v.s.sd[0] = 32'd10; v.s.sa[1] = 32'd200; v.s.sd[1] = 32'd9;
    v.s.sa[2] = 32'd4; v.s.sd[2] = 32'd11; v.s.sa[3] = 32'd8; v.s.sd[3] = 32'd12;
    v.s.sa[4] = 32'd200; v.s.sd[4] = 32'd0; v.s.sa[5] = 32'd12; v.s.sd[5] = 32'd13;
    v.e.pass = 1'b1; v.e.mc = 3'd4; v.e.ic = 16'd2; vecs[7] = v;

    // Reset state.
    #12;
    chk_zero("reset");
    @(negedge CLK); Reset = 1'b1; @(negedge CLK);
    chk_zero("post_reset");

    for (int i = 0; i < 8; i++) begin
      run_scn(vecs[i].s, 1'b1);
      chk_res($sformatf("vec%0d", i), vecs[i].e);
    end

    // Timeout lands exactly TMO edges after the start edge.
    s = base_vec().s;
    pulse_clear(); load_table(s); do_start(s);
    for (int t = 0; t < TMO - 1; t++) @(negedge CLK);
    chk("tmo.busy_before", 64'(busy), 64'd1);
    chk("tmo.fail_before", 64'(fail), 64'd0);
    @(negedge CLK);
    chk("tmo.fail_at", 64'(fail), 64'd1);
    chk("tmo.code_at", 64'(fail_code), 64'd2);
    chk("tmo.addr_at", 64'(fail_addr), 64'd0);

    // Completing match in the last allowed cycle still passes.
    pulse_clear(); do_start(s);
    for (int t = 0; t < TMO - 1; t++) @(negedge CLK);
    MemWrite = 1'b1; DataAdr = 32'd84; WriteData = 32'd71; @(negedge CLK); MemWrite = 1'b0;
    chk("late.pass", 64'(pass), 64'd1);
    chk("late.code", 64'(fail_code), 64'd0);

    // Pass latency is one cycle after the completing store.
    pulse_clear(); do_start(s);
    MemWrite = 1'b1; DataAdr = 32'd84; WriteData = 32'd71; @(posedge CLK); #1;
    chk("lat.pass", 64'(pass), 64'd1);
    @(negedge CLK); MemWrite = 1'b0;
    // start outside IDLE is ignored; PASS holds.
    start = 1'b1; @(negedge CLK); start = 1'b0; @(negedge CLK);
    chk("hold.pass", 64'(pass), 64'd1);
    chk("hold.busy", 64'(busy), 64'd0);

    // cfg_we while busy must not disturb the table.
    pulse_clear(); do_start(s);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'h99; cfg_data = 32'd1; @(negedge CLK); cfg_we = 1'b0;
    MemWrite = 1'b1; DataAdr = 32'd84; WriteData = 32'd71; @(negedge CLK); MemWrite = 1'b0;
    chk("cfgbusy.pass", 64'(pass), 64'd1);

    // clear during RUN returns to IDLE with zeroed status.
    pulse_clear(); do_start(s);
    MemWrite = 1'b1; DataAdr = 32'd80; WriteData = 32'd1; @(negedge CLK); MemWrite = 1'b0;
    chk("clrrun.ign", 64'(ign_cnt), 64'd1);
    pulse_clear();
    chk_zero("clrrun");

    // cfg_num=0 passes immediately; clear then zeroes everything.
    s.num = 3'd0;
    do_start(s);
    chk("num0.pass", 64'(pass), 64'd1);
    pulse_clear();
    chk_zero("num0.clear");

    // Asynchronous reset mid-RUN; table contents survive it.
    s = vecs[0].s;
    pulse_clear(); do_start(s); @(negedge CLK);
    chk("rst.busy_before", 64'(busy), 64'd1);
    #2 Reset = 1'b0; #1;
    chk_zero("rst.async");
    @(negedge CLK); Reset = 1'b1; @(negedge CLK);
    run_scn(s, 1'b0);
    chk_res("rst.rearm", vecs[0].e);

    // Random scenarios against the reference model.
    for (int i = 0; i < 40; i++) begin
      s = rand_scn();
      e = model(s);
      run_scn(s, 1'b1);
      chk_res($sformatf("rnd%0d", i), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
